// File: rtl/comp_pkg.sv
// rtl/comp_pkg.sv - shared state encodings and result codes for the serial magnitude comparator
package comp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Result codes packed as {gt, lt, eq}
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_GT   = 3'b100;
    localparam logic [2:0] RES_LT   = 3'b010;
    localparam logic [2:0] RES_EQ   = 3'b001;

endpackage

// File: rtl/comp_bit_cell.sv
// rtl/comp_bit_cell.sv - combinational 1-bit magnitude compare cell
module comp_bit_cell (
    input  logic i_a,
    input  logic i_b,
    output logic o_gt,
    output logic o_lt,
    output logic o_eq
);

    // Single-bit relations; exactly one output is high
    always_comb begin
        o_gt = i_a & ~i_b;
        o_lt = ~i_a & i_b;
        o_eq = ~(i_a ^ i_b);
    end

endmodule

// File: rtl/serial_mag_comp.sv
// rtl/serial_mag_comp.sv - bit-serial MSB-first magnitude comparator (optional SERIAL_COMP_EARLY_EXIT_EN)
module serial_mag_comp
    import comp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [CW-1:0]    r_cnt;
    logic             r_decided;
    logic             r_dec_gt;
    logic [2:0]       r_res;

    logic             w_bit_gt;
    logic             w_bit_lt;
    logic             w_bit_eq;
    logic             w_hit;
    logic             w_last;
    logic             w_finish;
    logic [2:0]       w_res_nxt;

    comp_bit_cell u_cell (
        .i_a  (r_sh_a[WIDTH-1]),
        .i_b  (r_sh_b[WIDTH-1]),
        .o_gt (w_bit_gt),
        .o_lt (w_bit_lt),
        .o_eq (w_bit_eq)
    );

    // First differing bit wins; counter hitting 1 means this edge consumes the last bit
    always_comb begin
        w_hit  = ~r_decided & ~w_bit_eq;
        w_last = (r_cnt == CW'(1));
`ifdef SERIAL_COMP_EARLY_EXIT_EN
        w_finish = w_last | w_hit;
`else
        w_finish = w_last;
`endif
        if (w_hit)
            w_res_nxt = {w_bit_gt, w_bit_lt, 1'b0};
        else if (r_decided)
            w_res_nxt = r_dec_gt ? RES_GT : RES_LT;
        else
            w_res_nxt = RES_EQ;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_finish) w_state_nxt = ST_DONE;
            ST_DONE:  if (out_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand shifters, bit counter, decision flag and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_a    <= '0;
            r_sh_b    <= '0;
            r_cnt     <= '0;
            r_decided <= 1'b0;
            r_dec_gt  <= 1'b0;
            r_res     <= RES_NONE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_sh_a    <= a;
                        r_sh_b    <= b;
                        r_cnt     <= CW'(WIDTH);
                        r_decided <= 1'b0;
                        r_dec_gt  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (w_hit) begin
                        r_decided <= 1'b1;
                        r_dec_gt  <= w_bit_gt;
                    end
                    r_sh_a <= {r_sh_a[WIDTH-2:0], 1'b0};
                    r_sh_b <= {r_sh_b[WIDTH-2:0], 1'b0};
                    r_cnt  <= r_cnt - CW'(1);
                    if (w_finish)
                        r_res <= w_res_nxt;
                end
                default: ;
            endcase
        end
    end

    // Handshake decode and held result
    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_DONE);
        gt        = r_res[2];
        lt        = r_res[1];
        eq        = r_res[0];
    end

endmodule
